mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single main-memory port between I-cache fill requests and D-cache fill/writeback requests.
//  Sits between the two cache controllers inside proc_hier and the memory model.
//  Fixed D-side priority, with a starvation guard that forces an I-side grant.
//  One transaction is outstanding at a time.
// PARAMETERS
//  ADDR_W        16  address width
//  DATA_W        16  data width
//  STARVE_LIMIT   4  consecutive D grants with i_req waiting before I is forced; >=1
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous, active-low reset
//  i_req      in   1       I-cache read request; held with i_addr until i_done
//  i_addr     in   ADDR_W  I-cache read address
//  i_done     out  1       one-cycle pulse, I transaction complete
//  i_rdata    out  DATA_W  read data, valid with i_done, else 0
//  d_req      in   1       D-cache request; held with d_wr/d_addr/d_wdata until d_done
//  d_wr       in   1       1 = write, 0 = read
//  d_addr     in   ADDR_W  D-cache address
//  d_wdata    in   DATA_W  D-cache write data
//  d_done     out  1       one-cycle pulse, D transaction complete
//  d_rdata    out  DATA_W  read data, valid with d_done on reads, else 0
//  mem_req    out  1       one-cycle start pulse to memory
//  mem_wr     out  1       write enable, held for the whole transaction
//  mem_addr   out  ADDR_W  address, held for the whole transaction
//  mem_wdata  out  DATA_W  write data, held for the whole transaction
//  mem_rdata  in   DATA_W  memory read data, valid with mem_done
//  mem_done   in   1       memory completion pulse; latency >=1 cycle after mem_req
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  Reset values:
//   - state = IDLE; d_streak = 0; last = none.
//   - All outputs 0.
//   - Reset is asynchronous: asserting rst mid-transaction abandons it.
//   - No done pulse is produced for an abandoned transaction.
//   - The memory model is reset by the same rst.
//  States: IDLE, BUSY_I, BUSY_D.
//  Grant decision (evaluated in IDLE, and at a completing edge):
//   - Requesters are i_req and d_req, excluding `last`.
//   - `last` is the requester completing this cycle; it is set only at a completing edge.
//   - If d_streak == STARVE_LIMIT and i_req is eligible: grant I.
//   - Otherwise, if d_req is eligible: grant D.
//   - Otherwise, if i_req is eligible: grant I.
//   - Otherwise, go to IDLE.
//  Grant edge:
//   - Register mem_addr, mem_wr and mem_wdata; mem_wr and mem_wdata are 0 for I grants.
//   - Enter BUSY_x.
//   - mem_req = 1 in the first BUSY cycle only.
//  mem_done while in BUSY_x:
//   - Combinationally, x_done = 1 and x_rdata = mem_rdata (0 for D writes).
//   - At that edge, apply the grant decision again, with no idle bubble between different requesters.
//   - The same requester needs at least one IDLE cycle before being re-granted.
//  mem_done in IDLE is ignored.
//  d_streak:
//   - +1 (saturating at STARVE_LIMIT) on a D grant while i_req = 1.
//   - Cleared on an I grant, or on a D grant while i_req = 0.
//  Latency: req at cycle 0 -> mem_req at cycle 1 -> done in the cycle mem_done arrives (>= cycle 2).
//  Requester signals changing before done are a protocol violation; the latched values are used.
//  mem_addr, mem_wr and mem_wdata return to 0 on entering IDLE.
// CONFIGURATION
//  MEM_ARB_STATS_EN defined: adds three outputs, each 16 bits, reset 0, saturating at 0xFFFF.
//   - stat_i_grants: +1 per I grant.
//   - stat_d_grants: +1 per D grant.
//   - stat_i_wait: +1 per cycle with i_req = 1 and no I transaction active.
//  MEM_ARB_STATS_EN undefined: the ports and counters are absent; all other behaviour is identical.
// TESTING
//  1. I only: i_req, i_addr=0x0040; mem_done 3 cycles after mem_req with rdata 0xBEEF
//     -> mem_req at cycle 1, mem_addr=0x0040, mem_wr=0; i_done with i_rdata=0xBEEF at cycle 4.
//  2. i_req and d_req both rise at cycle 0
//     -> D granted first; I's mem_req in the cycle after d_done (no IDLE cycle).
//  3. D write: d_wr=1, d_addr=0x1000, d_wdata=0x1234
//     -> mem_wr, addr and data held until mem_done; d_done with d_rdata=0; busy falls next cycle.
//  4. Starvation, STARVE_LIMIT=4: i_req held; d_req re-raised 1 cycle after each done
//     -> exactly 4 D grants, then an I grant; d_streak returns to 0.
//  5. rst low 2 cycles into BUSY_D
//     -> all outputs 0 immediately; no d_done.
//     After release with no requests, busy=0; mem_done pulses are ignored.
//  6. MEM_ARB_STATS_EN: run scenario 2
//     -> stat_d_grants=1, stat_i_grants=1, stat_i_wait = cycles before I's grant edge.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the I/D cache controllers, the arbiter and memory.
// master: arbiter view; slave: cache/memory environment view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_done;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_req;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;

  modport master (
    input  i_req, i_addr,
    input  d_req, d_wr, d_addr, d_wdata,
    input  mem_rdata, mem_done,
    output i_done, i_rdata,
    output d_done, d_rdata,
    output mem_req, mem_wr,
    output mem_addr, mem_wdata
  );

  modport slave (
    output i_req, i_addr,
    output d_req, d_wr, d_addr, d_wdata,
    output mem_rdata, mem_done,
    input  i_done, i_rdata,
    input  d_done, d_rdata,
    input  mem_req, mem_wr,
    input  mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// I/D fill arbiter for the single memory port: D priority, starvation guard.
// Ports: clk, rst (async active-low), bus (mem_arbiter_if.master), busy.
// MEM_ARB_STATS_EN adds stat_i_grants, stat_d_grants, stat_i_wait.
module mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus,
  output logic          busy
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]   stat_i_grants,
  output logic [15:0]   stat_d_grants,
  output logic [15:0]   stat_i_wait
`endif
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  state_t            state;
  state_t            stateNext;
  logic [SW-1:0]     dStreak;
  logic              memReq;
  logic              memWr;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;

  logic doneI;
  logic doneD;
  logic decide;
  logic iElig;
  logic dElig;
  logic grantI;
  logic grantD;

  // The requester completing this cycle is excluded from the
  // decision, so it always sees at least one IDLE cycle.
  always_comb begin
    stateNext = state;
    grantI    = 1'b0;
    grantD    = 1'b0;
    doneI     = (state == BUSY_I) && bus.mem_done;
    doneD     = (state == BUSY_D) && bus.mem_done;
    decide    = (state == IDLE) || doneI || doneD;
    iElig     = bus.i_req && !doneI;
    dElig     = bus.d_req && !doneD;
    if (decide) begin
      if (iElig && (dStreak == LIMIT)) begin
        grantI = 1'b1;
      end else if (dElig) begin
        grantD = 1'b1;
      end else if (iElig) begin
        grantI = 1'b1;
      end
      if (grantI) begin
        stateNext = BUSY_I;
      end else if (grantD) begin
        stateNext = BUSY_D;
      end else begin
        stateNext = IDLE;
      end
    end
  end

  always_comb begin
    bus.i_done  = doneI;
    bus.i_rdata = '0;
    bus.d_done  = doneD;
    bus.d_rdata = '0;
    if (doneI) begin
      bus.i_rdata = bus.mem_rdata;
    end
    if (doneD && !memWr) begin
      bus.d_rdata = bus.mem_rdata;
    end
  end

  assign bus.mem_req   = memReq;
  assign bus.mem_wr    = memWr;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      dStreak  <= '0;
      memReq   <= 1'b0;
      memWr    <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
    end else begin
      state  <= stateNext;
      memReq <= grantI || grantD;
      if (grantI) begin
        memAddr  <= bus.i_addr;
        memWr    <= 1'b0;
        memWdata <= '0;
        dStreak  <= '0;
      end else if (grantD) begin
        memAddr  <= bus.d_addr;
        memWr    <= bus.d_wr;
        memWdata <= bus.d_wdata;
        if (!bus.i_req) begin
          dStreak <= '0;
        end else if (dStreak != LIMIT) begin
          dStreak <= dStreak + 1'b1;
        end
      end else if (decide) begin
        memAddr  <= '0;
        memWr    <= 1'b0;
        memWdata <= '0;
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic iWaiting;
  assign iWaiting = bus.i_req && (state != BUSY_I);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_i_grants <= '0;
      stat_d_grants <= '0;
      stat_i_wait   <= '0;
    end else begin
      if (grantI && (stat_i_grants != 16'hFFFF)) begin
        stat_i_grants <= stat_i_grants + 16'd1;
      end
      if (grantD && (stat_d_grants != 16'hFFFF)) begin
        stat_d_grants <= stat_d_grants + 16'd1;
      end
      if (iWaiting && (stat_i_wait != 16'hFFFF)) begin
        stat_i_wait <= stat_i_wait + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; the bench acts as the memory model.
// Checks grant order, latency, hold, starvation forcing and reset abort.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  logic busy;
  int   total;
  int   passed;
  int   failed;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] statI;
  logic [15:0] statD;
  logic [15:0] statW;
`endif

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_arbiter #(
    .ADDR_W(16),
    .DATA_W(16),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .busy(busy)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_i_grants(statI),
    .stat_d_grants(statD),
    .stat_i_wait(statW)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  initial begin
    total         = 0;
    passed        = 0;
    failed        = 0;
    rst           = 1'b0;
    bus.i_req     = 1'b0;
    bus.i_addr    = '0;
    bus.d_req     = 1'b0;
    bus.d_wr      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_done  = 1'b0;
    #3;
    chk("rst busy", 32'(busy), 0);
    chk("rst mem_req", 32'(bus.mem_req), 0);
    chk("rst mem_addr", 32'(bus.mem_addr), 0);
    chk("rst i_done", 32'(bus.i_done), 0);
    tick;
    tick;
    rst = 1'b1;

    // 1: I only, memory latency 3
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h0040;
    #1 chk("t1 c0 busy", 32'(busy), 0);
    tick;
    chk("t1 mem_req", 32'(bus.mem_req), 1);
    chk("t1 mem_addr", 32'(bus.mem_addr), 32'h0040);
    chk("t1 mem_wr", 32'(bus.mem_wr), 0);
    tick;
    chk("t1 req pulse", 32'(bus.mem_req), 0);
    tick;
    chk("t1 no early done", 32'(bus.i_done), 0);
    tick;
    bus.mem_done  = 1'b1;
    bus.mem_rdata = 16'hBEEF;
    #1 chk("t1 i_done", 32'(bus.i_done), 1);
    chk("t1 i_rdata", 32'(bus.i_rdata), 32'hBEEF);
    chk("t1 d_done", 32'(bus.d_done), 0);
    tick;
    bus.mem_done = 1'b0;
    bus.i_req    = 1'b0;
    #1 chk("t1 idle", 32'(busy), 0);
    chk("t1 addr clr", 32'(bus.mem_addr), 0);
    chk("t1 rdata 0", 32'(bus.i_rdata), 0);

    // 2: I and D together, D first, I with no bubble
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h0080;
    bus.d_req  = 1'b1;
    bus.d_wr   = 1'b0;
    bus.d_addr = 16'h2000;
    tick;
    chk("t2 d first", 32'(bus.mem_addr), 32'h2000);
    chk("t2 mem_req", 32'(bus.mem_req), 1);
    tick;
    bus.mem_done  = 1'b1;
    bus.mem_rdata = 16'h5555;
    #1 chk("t2 d_done", 32'(bus.d_done), 1);
    chk("t2 d_rdata", 32'(bus.d_rdata), 32'h5555);
    chk("t2 i_done", 32'(bus.i_done), 0);
    tick;
    bus.mem_done = 1'b0;
    bus.d_req    = 1'b0;
    #1 chk("t2 i busy", 32'(busy), 1);
    chk("t2 i mem_req", 32'(bus.mem_req), 1);
    chk("t2 i addr", 32'(bus.mem_addr), 32'h0080);
    tick;
    bus.mem_done  = 1'b1;
    bus.mem_rdata = 16'h0A0A;
    #1 chk("t2 i_done", 32'(bus.i_done), 1);
    chk("t2 i_rdata", 32'(bus.i_rdata), 32'h0A0A);
    tick;
    bus.mem_done = 1'b0;
    bus.i_req    = 1'b0;
    #1 chk("t2 idle", 32'(busy), 0);
`ifdef MEM_ARB_STATS_EN
    chk("st i_grants", 32'(statI), 2);
    chk("st d_grants", 32'(statD), 1);
    chk("st i_wait", 32'(statW), 4);
`endif

    // 3: D write held, then same-requester idle bubble
    bus.d_req   = 1'b1;
    bus.d_wr    = 1'b1;
    bus.d_addr  = 16'h1000;
    bus.d_wdata = 16'h1234;
    tick;
    chk("t3 mem_wr", 32'(bus.mem_wr), 1);
    chk("t3 wdata", 32'(bus.mem_wdata), 32'h1234);
    chk("t3 addr", 32'(bus.mem_addr), 32'h1000);
    tick;
    chk("t3 wr held", 32'(bus.mem_wr), 1);
    chk("t3 wdata held", 32'(bus.mem_wdata), 32'h1234);
    tick;
    bus.mem_done  = 1'b1;
    bus.mem_rdata = 16'h7777;
    #1 chk("t3 d_done", 32'(bus.d_done), 1);
    chk("t3 d_rdata 0", 32'(bus.d_rdata), 0);
    tick;
    bus.mem_done = 1'b0;
    #1 chk("t3 bubble", 32'(busy), 0);
    chk("t3 wr clr", 32'(bus.mem_wr), 0);
    chk("t3 wdata clr", 32'(bus.mem_wdata), 0);
    tick;
    chk("t3 regrant", 32'(bus.mem_req), 1);
    chk("t3 regrant wr", 32'(bus.mem_wr), 1);
    tick;
    bus.mem_done = 1'b1;
    #1 chk("t3 d_done2", 32'(bus.d_done), 1);
    tick;
    bus.mem_done = 1'b0;
    bus.d_req    = 1'b0;
    bus.d_wr     = 1'b0;
    #1 chk("t3 idle", 32'(busy), 0);

    // 4: four D grants with I waiting, then I forced
    for (int k = 0; k < 4; k++) begin
      bus.d_req  = 1'b1;
      bus.d_addr = 16'h3000 + 16'(k);
      bus.i_req  = 1'b1;
      bus.i_addr = 16'h0100;
      #1 chk("t4 idle", 32'(busy), 0);
      tick;
      chk("t4 d grant", 32'(bus.mem_addr),
          32'h3000 + 32'(k));
      bus.i_req = 1'b0;
      tick;
      bus.mem_done = 1'b1;
      #1 chk("t4 d_done", 32'(bus.d_done), 1);
      tick;
      bus.mem_done = 1'b0;
      bus.d_req    = 1'b0;
    end
    bus.d_req  = 1'b1;
    bus.d_addr = 16'h3004;
    bus.i_req  = 1'b1;
    tick;
    chk("t4 forced i", 32'(bus.mem_addr), 32'h0100);
    chk("t4 forced wr", 32'(bus.mem_wr), 0);
    tick;
    bus.mem_done  = 1'b1;
    bus.mem_rdata = 16'h1111;
    #1 chk("t4 i_done", 32'(bus.i_done), 1);
    chk("t4 i_rdata", 32'(bus.i_rdata), 32'h1111);
    tick;
    bus.mem_done = 1'b0;
    bus.i_req    = 1'b0;
    #1 chk("t4 d next", 32'(bus.mem_addr), 32'h3004);
    chk("t4 d req", 32'(bus.mem_req), 1);
    tick;
    bus.mem_done = 1'b1;
    #1 chk("t4 d_done2", 32'(bus.d_done), 1);
    tick;
    bus.mem_done = 1'b0;
    bus.d_addr   = 16'h3005;
    bus.i_req    = 1'b1;
    bus.i_addr   = 16'h0200;
    tick;
    chk("t4 streak clr", 32'(bus.mem_addr), 32'h3005);
    tick;
    bus.mem_done = 1'b1;
    #1 chk("t4 d_done3", 32'(bus.d_done), 1);
    tick;
    bus.mem_done = 1'b0;
    bus.d_req    = 1'b0;
    #1 chk("t4 i after", 32'(bus.mem_addr), 32'h0200);
    tick;
    bus.mem_done = 1'b1;
    #1 chk("t4 i_done2", 32'(bus.i_done), 1);
    tick;
    bus.mem_done = 1'b0;
    bus.i_req    = 1'b0;
    #1 chk("t4 idle end", 32'(busy), 0);

    // 5: reset 2 cycles into BUSY_D
    bus.d_req   = 1'b1;
    bus.d_wr    = 1'b1;
    bus.d_addr  = 16'h4000;
    bus.d_wdata = 16'hABCD;
    tick;
    chk("t5 busy", 32'(busy), 1);
    tick;
    rst       = 1'b0;
    bus.d_req = 1'b0;
    #1 chk("t5 busy 0", 32'(busy), 0);
    chk("t5 addr 0", 32'(bus.mem_addr), 0);
    chk("t5 wr 0", 32'(bus.mem_wr), 0);
    chk("t5 wdata 0", 32'(bus.mem_wdata), 0);
    tick;
    tick;
    rst          = 1'b1;
    bus.mem_done = 1'b1;
    #1 chk("t5 no d_done", 32'(bus.d_done), 0);
    chk("t5 no i_done", 32'(bus.i_done), 0);
    tick;
    bus.mem_done = 1'b0;
    #1 chk("t5 idle", 32'(busy), 0);
    chk("t5 no req", 32'(bus.mem_req), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
